nrisc_call_stack: RTL and testbench
===================================

Name: nrisc_call_stack

Overview:
- Hardware return-address/flag stack for the NRISC CPU.
- Consumes the CORE stack control, the current PC and the ULA flags.
- Produces STACK_OUT, which feeds the PC return path (selected when CORE_Status == 2'b11), and STACK_FLAGS, which restore the CORE flags on return.
- Supports nested CALL/RET up to DEPTH levels, with full/empty status and sticky error reporting.

Parameters:
- TAM, 16, data/PC width in bits.
- DEPTH, 8, number of stack entries; must be a power of two, at least 2.
- RET_OFFSET, 1, value added to PC on push to form the return address.

Ports:
- clk  in  1  main clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- STACK_ctrl  in  2  00 idle, 01 push, 10 pop, 11 replace (pop+push in one cycle).
- PC  in  TAM  current program counter.
- FLAGS_IN  in  3  CORE_ULA_flags to save with the return address.
- STACK_err_clr  in  1  clears the sticky error bits.
- STACK_OUT  out  TAM  return address at top of stack.
- STACK_FLAGS  out  3  flags at top of stack.
- STACK_empty  out  1  no valid entries.
- STACK_full  out  1  DEPTH valid entries.
- STACK_count  out  $clog2(DEPTH)+1  number of valid entries.
- STACK_overflow  out  1  sticky: a push was attempted while full.
- STACK_underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst=1 at a rising clk edge):
  - sp=0, count=0.
  - STACK_OUT=0, STACK_FLAGS=0, STACK_empty=1, STACK_full=0, overflow=0, underflow=0.
  - Array contents need not be cleared.
  - rst overrides any STACK_ctrl in the same cycle.
- Entry format: {FLAGS_IN[2:0], PC+RET_OFFSET}. The address add wraps modulo 2^TAM (PC=16'hFFFF, offset 1 stores 16'h0000).
- Push (01), not full:
  - writes the entry at index sp; sp increments.
  - the new top is visible on STACK_OUT/STACK_FLAGS the cycle after the edge (one-cycle latency).
- Push while full:
  - no write, sp unchanged, overflow set.
  - outputs keep the existing top.
- Pop (10), not empty:
  - sp decrements.
  - the outputs show the new top (the previous entry) the next cycle, or 0 if the stack is now empty.
- Pop while empty:
  - no change, underflow set, outputs stay 0.
- Replace (11), not empty:
  - overwrites entry sp-1 with the new entry; sp unchanged.
  - legal when full; never sets overflow.
- Replace while empty: behaves exactly as push; no underflow.
- Top-of-stack outputs are registered:
  - STACK_OUT and STACK_FLAGS always equal entry sp-1 when count>0, else 0.
  - Internal forwarding is required so the written value appears one cycle after push/replace. A registered read of the old array value is not acceptable.
- Status signals:
  - STACK_empty = (count==0); STACK_full = (count==DEPTH). Both are derived from registered count and are valid in the same cycle as STACK_OUT.
- STACK_err_clr clears both sticky bits on the next edge. If a new overflow/underflow occurs in the same cycle, the error wins and the bit stays 1.
- STACK_ctrl is sampled on every rising edge. The CPU must hold it for exactly one cycle per operation; the block does not edge-detect.
- The CPU samples flags on the falling clk edge, so STACK_FLAGS must be stable within half a cycle of the rising edge. Outputs are registered with no combinational path from inputs.

Decomposition:
- Shared package nrisc_pkg holds:
  - the STACK_ctrl encodings (STK_IDLE, STK_PUSH, STK_POP, STK_REPL);
  - the default TAM;
  - the flag-vector width constant (3).
- Sub-module nrisc_stack_ram: DEPTH x (TAM+3) array with one synchronous write port and an asynchronous read port.
- Pointer, count, forwarding and error logic stay in nrisc_call_stack.

Test Plan:
- Reset, then check: STACK_empty=1, count=0, STACK_OUT=0, error bits 0.
- Push with PC=16'h0010, FLAGS_IN=3'b101 -> next cycle STACK_OUT=16'h0011, STACK_FLAGS=3'b101, count=1. Pop -> STACK_OUT=0, empty=1.
- DEPTH=8: push PC=0..7, then a 9th push with PC=16'h00AA -> full=1, overflow=1, STACK_OUT=16'h0008. Pop 8 times -> outputs 16'h0007 down to 16'h0001, then 0.
- Pop while empty -> underflow=1. Assert err_clr in the same cycle as another empty pop -> underflow stays 1. err_clr alone -> underflow clears.
- Stack holding 16'h0021, then replace with PC=16'h0030 -> STACK_OUT=16'h0031, count unchanged. Replace on an empty stack -> count=1, no underflow.
- Push PC=16'hFFFF -> STACK_OUT=16'h0000. Assert rst during back-to-back pushes -> next cycle count=0, empty=1, and the push in the rst cycle is ignored.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared NRISC definitions: stack control encodings and common widths.
package nrisc_pkg;

  typedef enum logic [1:0] {
    STK_IDLE = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10,
    STK_REPL = 2'b11
  } stk_ctrl_e;

  localparam int TAM_DEFAULT = 16;
  localparam int FLAG_W      = 3;

endpackage

// File: rtl/nrisc_stack_ram.sv
// Call-stack storage: one synchronous write port, one asynchronous read port.
module nrisc_stack_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nrisc_call_stack.sv
// Return-address/flag stack for the NRISC CPU with registered top-of-stack
// outputs, full/empty status and sticky overflow/underflow flags.
module nrisc_call_stack
  import nrisc_pkg::*;
#(
  parameter int TAM        = TAM_DEFAULT,
  parameter int DEPTH      = 8,
  parameter int RET_OFFSET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               STACK_ctrl,
  input  logic [TAM-1:0]           PC,
  input  logic [2:0]               FLAGS_IN,
  input  logic                     STACK_err_clr,
  output logic [TAM-1:0]           STACK_OUT,
  output logic [2:0]               STACK_FLAGS,
  output logic                     STACK_empty,
  output logic                     STACK_full,
  output logic [$clog2(DEPTH):0]   STACK_count,
  output logic                     STACK_overflow,
  output logic                     STACK_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TAM + FLAG_W;

  stk_ctrl_e     ctrl;
  logic [CW-1:0] count, count_n;
  logic [EW-1:0] top_q, top_n;
  logic [EW-1:0] entry;
  logic [EW-1:0] rd_data;
  logic [AW-1:0] waddr, rd_addr, top_idx;
  logic [CW-1:0] cnt_m1, cnt_m2;
  logic          we;
  logic          empty, full;
  logic          ovf_q, ovf_n, unf_q, unf_n;

  assign ctrl    = stk_ctrl_e'(STACK_ctrl);
  assign entry   = {FLAGS_IN, PC + TAM'(RET_OFFSET)};
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign cnt_m1  = count - CW'(1);
  assign cnt_m2  = count - CW'(2);
  assign top_idx = cnt_m1[AW-1:0];
  // Entry below the current top, which becomes the new top after a pop.
  assign rd_addr = cnt_m2[AW-1:0];

  nrisc_stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (entry),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    count_n = count;
    top_n   = top_q;
    we      = 1'b0;
    waddr   = count[AW-1:0];
    ovf_n   = ovf_q & ~STACK_err_clr;
    unf_n   = unf_q & ~STACK_err_clr;
    case (ctrl)
      STK_PUSH: begin
        if (full) begin
          ovf_n = 1'b1;
        end else begin
          we      = 1'b1;
          count_n = count + CW'(1);
          top_n   = entry;
        end
      end
      STK_POP: begin
        if (empty) begin
          unf_n = 1'b1;
        end else begin
          count_n = cnt_m1;
          top_n   = (count == CW'(1)) ? '0 : rd_data;
        end
      end
      STK_REPL: begin
        // Written entry is forwarded straight into the top register.
        we    = 1'b1;
        top_n = entry;
        if (empty) count_n = count + CW'(1);
        else       waddr   = top_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      count <= count_n;
      top_q <= top_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
    end
  end

  assign STACK_OUT       = top_q[TAM-1:0];
  assign STACK_FLAGS     = top_q[EW-1:TAM];
  assign STACK_empty     = empty;
  assign STACK_full      = full;
  assign STACK_count     = count;
  assign STACK_overflow  = ovf_q;
  assign STACK_underflow = unf_q;

endmodule

// File: tb/tb_nrisc_call_stack.sv
// Directed self-checking bench for nrisc_call_stack (TAM=16, DEPTH=8).
module tb_nrisc_call_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  STACK_ctrl = 2'b00;
  logic [15:0] PC = '0;
  logic [2:0]  FLAGS_IN = '0;
  logic        STACK_err_clr = 1'b0;
  logic [15:0] STACK_OUT;
  logic [2:0]  STACK_FLAGS;
  logic        STACK_empty, STACK_full;
  logic [3:0]  STACK_count;
  logic        STACK_overflow, STACK_underflow;

  int vectors = 0;
  int errors  = 0;

  nrisc_call_stack #(.TAM(16), .DEPTH(8), .RET_OFFSET(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .STACK_ctrl      (STACK_ctrl),
    .PC              (PC),
    .FLAGS_IN        (FLAGS_IN),
    .STACK_err_clr   (STACK_err_clr),
    .STACK_OUT       (STACK_OUT),
    .STACK_FLAGS     (STACK_FLAGS),
    .STACK_empty     (STACK_empty),
    .STACK_full      (STACK_full),
    .STACK_count     (STACK_count),
    .STACK_overflow  (STACK_overflow),
    .STACK_underflow (STACK_underflow)
  );

  always #5 clk = ~clk;

  // Applies one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [1:0] c, input logic [15:0] pc,
                      input logic [2:0] f, input logic clr, input logic r);
    STACK_ctrl = c; PC = pc; FLAGS_IN = f; STACK_err_clr = clr; rst = r;
    @(posedge clk);
    #1;
    STACK_ctrl = 2'b00; STACK_err_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    step(2'b00, 16'h0, 3'b0, 1'b0, 1'b1);
    vectors++;
    if ({STACK_empty, STACK_full, STACK_count, STACK_OUT, STACK_FLAGS,
         STACK_overflow, STACK_underflow} !== {1'b1, 1'b0, 4'd0, 16'h0, 3'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: empty=%b full=%b count=%0d out=%h flags=%b ovf=%b unf=%b",
               STACK_empty, STACK_full, STACK_count, STACK_OUT, STACK_FLAGS,
               STACK_overflow, STACK_underflow);
    end
  endtask

  task automatic test_push_pop();
    step(2'b01, 16'h0010, 3'b101, 1'b0, 1'b0);
    vectors++;
    if ({STACK_OUT, STACK_FLAGS, STACK_count, STACK_empty} !== {16'h0011, 3'b101, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL push1: out=%h flags=%b count=%0d empty=%b expected 0011 101 1 0",
               STACK_OUT, STACK_FLAGS, STACK_count, STACK_empty);
    end
    step(2'b10, 16'h0, 3'b0, 1'b0, 1'b0);
    vectors++;
    if ({STACK_OUT, STACK_FLAGS, STACK_count, STACK_empty} !== {16'h0, 3'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL pop1: out=%h flags=%b count=%0d empty=%b expected 0000 000 0 1",
               STACK_OUT, STACK_FLAGS, STACK_count, STACK_empty);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      step(2'b01, 16'(i), 3'(i), 1'b0, 1'b0);
      vectors++;
      if (STACK_OUT !== 16'(i + 1) || STACK_FLAGS !== 3'(i) || STACK_count !== 4'(i + 1)) begin
        errors++;
        $display("FAIL fill[%0d]: out=%h flags=%b count=%0d expected %h %b %0d",
                 i, STACK_OUT, STACK_FLAGS, STACK_count, 16'(i + 1), 3'(i), i + 1);
      end
    end
    step(2'b01, 16'h00AA, 3'b111, 1'b0, 1'b0);
    vectors++;
    if ({STACK_full, STACK_overflow, STACK_OUT, STACK_FLAGS, STACK_count} !==
        {1'b1, 1'b1, 16'h0008, 3'b111, 4'd8}) begin
      errors++;
      $display("FAIL overflow: full=%b ovf=%b out=%h flags=%b count=%0d expected 1 1 0008 111 8",
               STACK_full, STACK_overflow, STACK_OUT, STACK_FLAGS, STACK_count);
    end
    step(2'b00, 16'h0, 3'b0, 1'b1, 1'b0);
    vectors++;
    if (STACK_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b expected 0", STACK_overflow);
    end
    step(2'b11, 16'h0050, 3'b011, 1'b0, 1'b0);
    vectors++;
    if ({STACK_OUT, STACK_FLAGS, STACK_count, STACK_overflow, STACK_full} !==
        {16'h0051, 3'b011, 4'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL repl_full: out=%h flags=%b count=%0d ovf=%b full=%b expected 0051 011 8 0 1",
               STACK_OUT, STACK_FLAGS, STACK_count, STACK_overflow, STACK_full);
    end
    for (int k = 1; k <= 8; k++) begin
      step(2'b10, 16'h0, 3'b0, 1'b0, 1'b0);
      exp = 16'(8 - k);
      vectors++;
      if (STACK_OUT !== exp || STACK_count !== 4'(8 - k) || STACK_full !== 1'b0) begin
        errors++;
        $display("FAIL drain[%0d]: out=%h count=%0d full=%b expected %h %0d 0",
                 k, STACK_OUT, STACK_count, STACK_full, exp, 8 - k);
      end
    end
    vectors++;
    if (STACK_empty !== 1'b1 || STACK_underflow !== 1'b0) begin
      errors++;
      $display("FAIL drained: empty=%b unf=%b expected 1 0", STACK_empty, STACK_underflow);
    end
  endtask

  task automatic test_underflow();
    step(2'b10, 16'h0, 3'b0, 1'b0, 1'b0);
    vectors++;
    if ({STACK_underflow, STACK_OUT, STACK_count, STACK_empty} !== {1'b1, 16'h0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL underflow: unf=%b out=%h count=%0d empty=%b expected 1 0000 0 1",
               STACK_underflow, STACK_OUT, STACK_count, STACK_empty);
    end
    step(2'b10, 16'h0, 3'b0, 1'b1, 1'b0);
    vectors++;
    if (STACK_underflow !== 1'b1) begin
      errors++;
      $display("FAIL unf_clr_race: unf=%b expected 1", STACK_underflow);
    end
    step(2'b00, 16'h0, 3'b0, 1'b1, 1'b0);
    vectors++;
    if (STACK_underflow !== 1'b0) begin
      errors++;
      $display("FAIL unf_clr: unf=%b expected 0", STACK_underflow);
    end
  endtask

  task automatic test_replace();
    step(2'b01, 16'h0020, 3'b001, 1'b0, 1'b0);
    step(2'b01, 16'h0040, 3'b100, 1'b0, 1'b0);
    step(2'b11, 16'h0030, 3'b010, 1'b0, 1'b0);
    vectors++;
    if ({STACK_OUT, STACK_FLAGS, STACK_count} !== {16'h0031, 3'b010, 4'd2}) begin
      errors++;
      $display("FAIL replace: out=%h flags=%b count=%0d expected 0031 010 2",
               STACK_OUT, STACK_FLAGS, STACK_count);
    end
    step(2'b10, 16'h0, 3'b0, 1'b0, 1'b0);
    vectors++;
    if ({STACK_OUT, STACK_FLAGS, STACK_count} !== {16'h0021, 3'b001, 4'd1}) begin
      errors++;
      $display("FAIL repl_below: out=%h flags=%b count=%0d expected 0021 001 1",
               STACK_OUT, STACK_FLAGS, STACK_count);
    end
    step(2'b11, 16'h0030, 3'b110, 1'b0, 1'b0);
    vectors++;
    if ({STACK_OUT, STACK_FLAGS, STACK_count} !== {16'h0031, 3'b110, 4'd1}) begin
      errors++;
      $display("FAIL replace1: out=%h flags=%b count=%0d expected 0031 110 1",
               STACK_OUT, STACK_FLAGS, STACK_count);
    end
    step(2'b10, 16'h0, 3'b0, 1'b0, 1'b0);
    step(2'b11, 16'h0077, 3'b011, 1'b0, 1'b0);
    vectors++;
    if ({STACK_OUT, STACK_FLAGS, STACK_count, STACK_underflow, STACK_empty} !==
        {16'h0078, 3'b011, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL repl_empty: out=%h flags=%b count=%0d unf=%b empty=%b expected 0078 011 1 0 0",
               STACK_OUT, STACK_FLAGS, STACK_count, STACK_underflow, STACK_empty);
    end
    step(2'b10, 16'h0, 3'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    step(2'b01, 16'hFFFF, 3'b010, 1'b0, 1'b0);
    vectors++;
    if ({STACK_OUT, STACK_FLAGS, STACK_count} !== {16'h0000, 3'b010, 4'd1}) begin
      errors++;
      $display("FAIL wrap: out=%h flags=%b count=%0d expected 0000 010 1",
               STACK_OUT, STACK_FLAGS, STACK_count);
    end
    step(2'b01, 16'h0100, 3'b001, 1'b0, 1'b0);
    step(2'b01, 16'h0200, 3'b001, 1'b0, 1'b1);
    vectors++;
    if ({STACK_count, STACK_empty, STACK_OUT, STACK_FLAGS} !== {4'd0, 1'b1, 16'h0, 3'b0}) begin
      errors++;
      $display("FAIL rst_push: count=%0d empty=%b out=%h flags=%b expected 0 1 0000 000",
               STACK_count, STACK_empty, STACK_OUT, STACK_FLAGS);
    end
    step(2'b00, 16'h0, 3'b0, 1'b0, 1'b0);
    vectors++;
    if (STACK_count !== 4'd0 || STACK_empty !== 1'b1) begin
      errors++;
      $display("FAIL post_rst: count=%0d empty=%b expected 0 1", STACK_count, STACK_empty);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
